// File: rtl/icache_fetch.sv
// Direct-mapped, read-only instruction cache feeding the fetch stage.
// A miss stalls the core while the whole line is refilled word 0 first over a req/ack port.
module icache_fetch #(
   parameter int LINES      = 16,
   parameter int LINE_WORDS = 4,
   parameter int AW         = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] PCF,
   output logic [31:0]   InstrF,
   output logic          StallIC,
   input  logic          inv,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   miss_count
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(LINES);
   localparam int TW = AW - IW - OW - 2;
   localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FILL   = 2'd1;
   localparam logic [1:0] UPDATE = 2'd2;

   logic [1:0]       state;
   logic [31:0]      data_mem [LINES][LINE_WORDS];
   logic [TW-1:0]    tag_mem  [LINES];
   logic [LINES-1:0] valid;
   logic [31:0]      line_buf [LINE_WORDS];
   logic [TW-1:0]    fill_tag;
   logic [IW-1:0]    fill_index;
   logic [OW-1:0]    beat;
   logic             abort;

   logic [OW-1:0] offset;
   logic [IW-1:0] index;
   logic [TW-1:0] tag;
   logic          hit;
   logic          unused_bits;

   assign offset      = PCF[OW+1:2];
   assign index       = PCF[IW+OW+1:OW+2];
   assign tag         = PCF[AW-1:IW+OW+2];
   assign unused_bits = ^PCF[1:0];

   // Lookups only count while idle, so a fill in progress always reads as a stall.
   assign hit      = valid[index] && (tag_mem[index] == tag) && (state == IDLE);
   assign InstrF   = hit ? data_mem[index][offset] : 32'h0;
   assign StallIC  = !hit;
   assign mem_req  = (state == FILL);
   assign mem_addr = {fill_tag, fill_index, beat, 2'b00};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         miss_count <= '0;
         beat       <= '0;
         abort      <= 1'b0;
         fill_tag   <= '0;
         fill_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (inv) begin
                  valid <= '0;
               end else if (!hit) begin
                  fill_tag   <= tag;
                  fill_index <= index;
                  beat       <= '0;
                  abort      <= 1'b0;
                  miss_count <= miss_count + 32'd1;
                  state      <= FILL;
               end
            end
            FILL: begin
               // An invalidate mid-fill lets the handshake finish but poisons the line.
               if (inv) begin
                  valid <= '0;
                  abort <= 1'b1;
               end
               if (mem_ack) begin
                  beat <= beat + OW'(1);
                  if (beat == LAST_BEAT) state <= UPDATE;
               end
            end
            UPDATE: begin
               if (inv) valid <= '0;
               else if (!abort) valid[fill_index] <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Arrays carry no reset; the valid bits alone decide what is usable.
   always_ff @(posedge clk) begin
      if (state == FILL && mem_ack) line_buf[beat] <= mem_rdata;
      if (state == UPDATE) begin
         for (int w = 0; w < LINE_WORDS; w++) data_mem[fill_index][w] <= line_buf[w];
         tag_mem[fill_index] <= fill_tag;
      end
   end
endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: a line-level cache model checked every cycle plus directed
// scenarios with hand-computed stall lengths, address sequences and counts.
module tb_icache_fetch;
   localparam int LINES = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] PCF;
   logic [31:0] InstrF;
   logic        StallIC;
   logic        inv;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] miss_count;

   int n_cmp = 0;
   int n_err = 0;
   int wait_cfg = 0;
   int wait_ctr = 0;
   logic stray_ack = 1'b0;
   logic [31:0] ack_log [$];

   icache_fetch #(.LINES(16), .LINE_WORDS(4), .AW(32)) dut (
      .clk(clk), .reset(rst_n), .PCF(PCF), .InstrF(InstrF), .StallIC(StallIC),
      .inv(inv), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Backing memory: contents are 0xE000_0000 + address, with wait_cfg idle cycles per beat.
   assign mem_ack   = (mem_req && (wait_ctr >= wait_cfg)) || stray_ack;
   assign mem_rdata = 32'hE000_0000 + mem_addr;

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_ctr <= wait_ctr + 1;
      else wait_ctr <= 0;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: resident lines by index plus a queue of fill addresses still owed.
   localparam int P_IDLE = 0;
   localparam int P_FILL = 1;
   localparam int P_UPD  = 2;
   int          phase = P_IDLE;
   bit          m_valid [LINES];
   logic [23:0] m_tag [LINES];
   logic [31:0] exp_q [$];
   int          m_fill_idx = 0;
   logic [23:0] m_fill_tag = '0;
   bit          m_abort = 1'b0;
   logic [31:0] m_count = '0;

   always @(negedge clk) begin
      int idx;
      logic [23:0] tg;
      bit m_hit;
      if (!rst_n) begin
         phase = P_IDLE;
         foreach (m_valid[i]) m_valid[i] = 1'b0;
         exp_q.delete();
         m_abort = 1'b0;
         m_count = '0;
         checkOutput("reset_stall", 32'(StallIC), 32'd1);
         checkOutput("reset_instr", InstrF, 32'h0);
         checkOutput("reset_req", 32'(mem_req), 32'd0);
         checkOutput("reset_count", miss_count, 32'd0);
      end else begin
         idx   = int'(PCF[7:4]);
         tg    = PCF[31:8];
         m_hit = (phase == P_IDLE) && m_valid[idx] && (m_tag[idx] == tg);
         checkOutput("model_stall", 32'(StallIC), 32'(!m_hit));
         checkOutput("model_instr", InstrF, m_hit ? 32'hE000_0000 + {PCF[31:2], 2'b00} : 32'h0);
         checkOutput("model_req", 32'(mem_req), 32'(phase == P_FILL));
         if (phase == P_FILL && exp_q.size() > 0) checkOutput("model_addr", mem_addr, exp_q[0]);
         checkOutput("model_count", miss_count, m_count);
         case (phase)
            P_IDLE: begin
               if (inv) begin
                  foreach (m_valid[i]) m_valid[i] = 1'b0;
               end else if (!m_hit) begin
                  m_count++;
                  m_fill_idx = idx;
                  m_fill_tag = tg;
                  m_abort    = 1'b0;
                  for (int b = 0; b < 4; b++) exp_q.push_back({PCF[31:4], 4'b0} + 32'(4 * b));
                  phase = P_FILL;
               end
            end
            P_FILL: begin
               if (inv) begin
                  foreach (m_valid[i]) m_valid[i] = 1'b0;
                  m_abort = 1'b1;
               end
               if (mem_ack && exp_q.size() > 0) void'(exp_q.pop_front());
               if (exp_q.size() == 0) phase = P_UPD;
            end
            default: begin
               if (!m_abort) begin
                  m_valid[m_fill_idx] = 1'b1;
                  m_tag[m_fill_idx]   = m_fill_tag;
               end
               if (inv) foreach (m_valid[i]) m_valid[i] = 1'b0;
               phase = P_IDLE;
            end
         endcase
      end
   end

   // Present a fetch address and count stalled cycles until it hits, logging acked addresses.
   task automatic applyStimulus(input logic [31:0] pc, output int cycles, output int acks,
                                output int unstable);
      logic [31:0] prev_addr;
      bit prev_pending;
      prev_addr    = '0;
      prev_pending = 1'b0;
      PCF = pc;
      #1;
      cycles   = 0;
      acks     = 0;
      unstable = 0;
      while (StallIC && cycles < 200) begin
         if (mem_req && prev_pending && mem_addr !== prev_addr) unstable++;
         if (mem_req && mem_ack) begin
            ack_log.push_back(mem_addr);
            acks++;
         end
         prev_pending = mem_req && !mem_ack;
         prev_addr    = mem_addr;
         cycles++;
         step();
      end
      if (StallIC) begin
         n_cmp++;
         n_err++;
         $display("[TB] FAIL hit_timeout: pc %h still stalled after %0d cycles", pc, cycles);
      end
   endtask

   task automatic check_log(input string name, input logic [31:0] base);
      checkOutput({name, "_n"}, 32'(ack_log.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         checkOutput(name, (i < ack_log.size()) ? ack_log[i] : 32'hFFFF_FFFF, base + 32'(4 * i));
   endtask

   initial begin
      int cyc, acks, unst;
      rst_n = 1'b0;
      PCF   = 32'h0;
      inv   = 1'b0;
      repeat (3) step();
      checkOutput("por_stall", 32'(StallIC), 32'd1);
      checkOutput("por_instr", InstrF, 32'h0);
      checkOutput("por_count", miss_count, 32'd0);
      rst_n = 1'b1;

      // Cold miss with zero-wait memory.
      ack_log.delete();
      applyStimulus(32'h0, cyc, acks, unst);
      checkOutput("cold_cycles", 32'(cyc), 32'd6);
      check_log("cold_addr", 32'h0);
      checkOutput("cold_instr", InstrF, 32'hE000_0000);
      checkOutput("cold_count", miss_count, 32'd1);

      // Sequential hits; stray acks with no request must be ignored.
      stray_ack = 1'b1;
      for (int k = 1; k < 4; k++) begin
         PCF = 32'(4 * k);
         #1;
         checkOutput("hit_stall", 32'(StallIC), 32'd0);
         checkOutput("hit_instr", InstrF, 32'hE000_0000 + 32'(4 * k));
         checkOutput("hit_req", 32'(mem_req), 32'd0);
         step();
      end
      stray_ack = 1'b0;
      checkOutput("hit_count", miss_count, 32'd1);

      // Conflict on index 0.
      applyStimulus(32'h100, cyc, acks, unst);
      checkOutput("conf_cycles", 32'(cyc), 32'd6);
      checkOutput("conf_instr", InstrF, 32'hE000_0100);
      applyStimulus(32'h0, cyc, acks, unst);
      checkOutput("conf_back_cycles", 32'(cyc), 32'd6);
      checkOutput("conf_count", miss_count, 32'd3);

      // Two wait cycles per beat.
      wait_cfg = 2;
      applyStimulus(32'h40, cyc, acks, unst);
      checkOutput("wait_cycles", 32'(cyc), 32'd14);
      checkOutput("wait_stable", 32'(unst), 32'd0);
      checkOutput("wait_instr", InstrF, 32'hE000_0040);
      checkOutput("wait_count", miss_count, 32'd4);

      // Invalidate during the second beat of a fill at 0x80.
      PCF = 32'h80;
      repeat (5) step();
      inv = 1'b1;
      step();
      inv = 1'b0;
      applyStimulus(32'h80, cyc, acks, unst);
      checkOutput("inv_cycles", 32'(cyc), 32'd22);
      checkOutput("inv_acks", 32'(acks), 32'd7);
      checkOutput("inv_count", miss_count, 32'd6);
      wait_cfg = 0;
      applyStimulus(32'h0, cyc, acks, unst);
      checkOutput("inv_old_cycles", 32'(cyc), 32'd6);
      checkOutput("inv_old_count", miss_count, 32'd7);

      // Reset in the middle of a fill, at beat 2.
      PCF = 32'hC0;
      repeat (3) step();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      checkOutput("rst_count", miss_count, 32'd0);
      checkOutput("rst_stall", 32'(StallIC), 32'd1);
      repeat (2) step();
      rst_n = 1'b1;
      ack_log.delete();
      applyStimulus(32'h0, cyc, acks, unst);
      checkOutput("post_rst_cycles", 32'(cyc), 32'd6);
      check_log("post_rst_addr", 32'h0);
      checkOutput("post_rst_instr", InstrF, 32'hE000_0000);
      checkOutput("post_rst_count", miss_count, 32'd1);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache that sits directly upstream of the pipelined ARM core's fetch stage.
- Consumes the core's fetch address PCF and returns InstrF.
- On a miss, it raises StallIC, which the hazard unit ORs into StallF/StallD. It then refills one line from a slower backing instruction memory using a req/ack handshake.
- Provides an invalidate input (for self-modifying code / program reload) and a miss counter for the testbench.

Parameters:
- LINES, 16, number of cache lines (power of 2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, at least 2).
- AW, 32, address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- PCF  input  AW  fetch byte address from the core; bits [1:0] are ignored.
- InstrF  output  32  instruction word to the core (decode register input).
- StallIC  output  1  stall request to the hazard unit; high while PCF is not a hit.
- inv  input  1  one-cycle pulse that invalidates all lines.
- mem_req  output  1  backing-memory word request.
- mem_addr  output  AW  word-aligned byte address of the requested word.
- mem_ack  input  1  backing memory returns mem_rdata this cycle.
- mem_rdata  input  32  word returned from backing memory.
- miss_count  output  32  number of misses since reset.

Behaviour:
- Address split (defaults):
  - offset = PCF[3:2] (log2 LINE_WORDS bits).
  - index = PCF[7:4] (log2 LINES bits).
  - tag = PCF[AW-1:8].
- Storage:
  - data array LINES x LINE_WORDS x 32.
  - tag array LINES x tag width.
  - valid bit per line.
  - Only the valid bits are reset.
- Hit is combinational: hit = valid[index] & (tag_array[index] == tag) & (state == IDLE).
  - On a hit: InstrF = data[index][offset], StallIC = 0.
  - Otherwise: InstrF = 32'h0, StallIC = 1.
- FSM states: IDLE, FILL, UPDATE.
  - IDLE, when !hit and inv is low:
    - latch fill_tag/fill_index from PCF;
    - beat = 0, abort = 0;
    - miss_count += 1 (wraps at 2^32);
    - go to FILL.
  - FILL:
    - mem_req = 1;
    - mem_addr = {fill_tag, fill_index, beat, 2'b00}, held stable until ack.
    - On mem_ack: write mem_rdata into line buffer word[beat] and beat += 1.
    - On the ack for beat LINE_WORDS-1, go to UPDATE.
    - The memory may ack in the same cycle req first rises (zero-wait) or any later cycle.
    - mem_ack while mem_req is low is ignored.
  - UPDATE:
    - write line buffer, tag and valid[fill_index] = !abort;
    - mem_req = 0;
    - go to IDLE.
    - The lookup is redone in IDLE against the current PCF.
- Refill order is always word 0 first; there is no critical-word-first.
- PCF may change during FILL (e.g. a branch redirect). The fill still completes into the latched index; the next IDLE cycle looks up the new PCF.
- inv handling:
  - In IDLE/UPDATE: clear all valid bits next edge. This takes priority over the UPDATE validate; the result is that the line stays invalid.
  - In IDLE with inv high: no miss is started that cycle.
  - In FILL: clear all valid bits and set abort. The fill runs to completion so that no handshake is left dangling, but the line is not validated.
- Reset values (asserted at any time, including mid-FILL):
  - state = IDLE, all valid = 0, mem_req = 0, miss_count = 0, beat = 0, abort = 0.
  - Combinational outputs after reset: StallIC = 1 and InstrF = 0 until the first fill completes.
  - An outstanding backing request is abandoned; the backing memory must tolerate a dropped request.
- Latency:
  - Miss with zero-wait memory: StallIC high for LINE_WORDS + 2 cycles (detect, LINE_WORDS beats, UPDATE). Hit data appears in the following cycle.
  - Each memory wait cycle adds one cycle.
- Conflict misses: a line fill overwrites whatever occupied that index (no replacement policy).

Test Plan:
- Cold miss at PCF=0x00 with zero-wait memory returning 0xE000_0000+addr:
  - StallIC high cycles 0-5, 6 cycles total;
  - mem_addr sequence 0x0, 0x4, 0x8, 0xC;
  - then InstrF=0xE000_0000 with StallIC=0;
  - miss_count=1.
- After the fill, step PCF 0x0 to 0x4, 0x8, 0xC: hits every cycle, InstrF=0xE000_0004/0008/000C, no mem_req, miss_count stays 1.
- Conflict: PCF=0x100 (same index 0, tag 1) misses and refills; returning to PCF=0x0 misses again; miss_count=3.
- Memory with 2 wait cycles per beat at PCF=0x40: StallIC high for 1+4*3+1=14 cycles; mem_addr stable while un-acked.
- inv pulsed during the second beat of a fill at PCF=0x80: the fill completes (4 acks), then an immediate re-miss at 0x80 (miss_count +1); also cached 0x0 now misses.
- reset low mid-FILL at beat 2: mem_req drops asynchronously, miss_count=0; after release PCF=0x0 misses cleanly from beat 0.
